// File: rtl/jtag_scan_sequencer.sv
// Command-driven JTAG master: walks the TAP through IR/DR scans, TAP resets and idle clocks,
// one command in flight, returning captured TDO on a valid/ready response port.
module jtag_scan_sequencer #(
   parameter int unsigned MAX_BITS = 64,
   parameter int unsigned TCK_HALF = 2,
   parameter int unsigned TRST_LEN = 4,
   localparam int unsigned LW = $clog2(MAX_BITS + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [LW-1:0]       cmd_len,
   input  logic [MAX_BITS-1:0] cmd_data,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [MAX_BITS-1:0] rsp_data,
   output logic                rsp_err,
   output logic                rsp_undriven,
   output logic                busy,
   output logic                jtag_TCK,
   output logic                jtag_TMS,
   output logic                jtag_TDI,
   output logic                jtag_TRSTn,
   input  logic                jtag_TDO_data,
   input  logic                jtag_TDO_driven
);

   localparam int unsigned PER = 2 * TCK_HALF;
   localparam int unsigned CW  = (PER > 1) ? $clog2(PER) : 1;
   localparam int unsigned IW  = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
   localparam int unsigned RW  = $clog2(TRST_LEN + 7);
   localparam int unsigned PW  = ((LW > RW) ? LW : RW) + 1;

   localparam logic [1:0] OpDr   = 2'b00;
   localparam logic [1:0] OpIr   = 2'b01;
   localparam logic [1:0] OpRst  = 2'b10;
   localparam logic [1:0] OpIdle = 2'b11;

   typedef enum logic [2:0] {StInitRst, StReady, StWalk, StShift, StPost, StResp} state_e;

   state_e              state_q;
   logic                init_q;
   logic [1:0]          op_q;
   logic [CW-1:0]       cnt_q;
   logic [PW-1:0]       per_q;
   logic [PW-1:0]       total_q;
   logic [PW-1:0]       walk_q;
   logic [PW-1:0]       len_q;
   logic [3:0]          walk_pat_q;
   logic [MAX_BITS-1:0] data_q;
   logic [IW-1:0]       bit_q;

   logic                tck_q, tms_q, tdi_q, trst_q;
   logic                cmd_ready_q, rsp_valid_q, rsp_err_q, rsp_undriven_q, busy_q;
   logic [MAX_BITS-1:0] rsp_data_q;

   state_e              nxt_state;
   logic                nxt_tms, nxt_tdi, nxt_trst;

   // Pin values for the period about to start, indexed by per_q within the current command.
   always_comb begin
      nxt_state = StShift;
      nxt_tms   = 1'b0;
      nxt_tdi   = 1'b0;
      nxt_trst  = 1'b1;
      if (op_q == OpRst) begin
         nxt_state = StInitRst;
         nxt_trst  = (per_q >= PW'(TRST_LEN));
         nxt_tms   = (per_q < PW'(TRST_LEN + 5));
      end else if (op_q == OpIdle) begin
         nxt_state = StShift;
      end else if (per_q < walk_q) begin
         nxt_state = StWalk;
         nxt_tms   = walk_pat_q[per_q[1:0]];
      end else if (per_q < walk_q + len_q) begin
         nxt_state = StShift;
         nxt_tdi   = data_q[0];
         nxt_tms   = (per_q == walk_q + len_q - PW'(1));
      end else begin
         nxt_state = StPost;
         nxt_tms   = (per_q == walk_q + len_q);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= StInitRst;
         init_q         <= 1'b1;
         op_q           <= OpRst;
         cnt_q          <= CW'(PER - 1);
         per_q          <= '0;
         total_q        <= PW'(TRST_LEN + 6);
         walk_q         <= '0;
         len_q          <= '0;
         walk_pat_q     <= '0;
         data_q         <= '0;
         bit_q          <= '0;
         tck_q          <= 1'b0;
         tms_q          <= 1'b1;
         tdi_q          <= 1'b0;
         trst_q         <= 1'b0;
         cmd_ready_q    <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_data_q     <= '0;
         rsp_err_q      <= 1'b0;
         rsp_undriven_q <= 1'b0;
         busy_q         <= 1'b1;
      end else begin
         unique case (state_q)
            StReady: begin
               if (cmd_valid) begin
                  cmd_ready_q    <= 1'b0;
                  busy_q         <= 1'b1;
                  init_q         <= 1'b0;
                  op_q           <= cmd_op;
                  data_q         <= cmd_data;
                  len_q          <= PW'(cmd_len);
                  walk_q         <= (cmd_op == OpIr) ? PW'(4) : PW'(3);
                  walk_pat_q     <= (cmd_op == OpIr) ? 4'b0011 : 4'b0001;
                  rsp_data_q     <= '0;
                  rsp_err_q      <= 1'b0;
                  rsp_undriven_q <= 1'b0;
                  bit_q          <= '0;
                  per_q          <= '0;
                  // Park in the last phase so the first period starts on the next clock.
                  cnt_q          <= CW'(PER - 1);
                  unique case (cmd_op)
                     OpDr, OpIr: begin
                        if (cmd_len == '0 || cmd_len > LW'(MAX_BITS)) begin
                           state_q     <= StResp;
                           rsp_err_q   <= 1'b1;
                           rsp_valid_q <= 1'b1;
                        end else begin
                           state_q <= StWalk;
                           total_q <= ((cmd_op == OpIr) ? PW'(4) : PW'(3)) + PW'(cmd_len)
                                      + PW'(2);
                        end
                     end
                     OpRst: begin
                        state_q <= StInitRst;
                        total_q <= PW'(TRST_LEN + 6);
                     end
                     default: begin
                        if (cmd_len == '0) begin
                           state_q     <= StResp;
                           rsp_valid_q <= 1'b1;
                        end else begin
                           state_q <= StShift;
                           total_q <= PW'(cmd_len);
                        end
                     end
                  endcase
               end
            end
            StInitRst, StWalk, StShift, StPost: begin
               if (cnt_q != CW'(PER - 1)) begin
                  cnt_q <= cnt_q + CW'(1);
                  if (cnt_q == CW'(TCK_HALF - 1)) begin
                     tck_q <= 1'b1;
                     if (state_q == StShift && !op_q[1]) begin
                        rsp_data_q[bit_q] <= jtag_TDO_driven & jtag_TDO_data;
                        if (!jtag_TDO_driven) rsp_undriven_q <= 1'b1;
                        bit_q <= bit_q + IW'(1);
                     end
                  end
               end else begin
                  cnt_q <= '0;
                  tck_q <= 1'b0;
                  if (per_q == total_q) begin
                     tdi_q <= 1'b0;
                     if (init_q) begin
                        state_q     <= StReady;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                     end else begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                     end
                  end else begin
                     state_q  <= nxt_state;
                     tms_q    <= nxt_tms;
                     tdi_q    <= nxt_tdi;
                     trst_q   <= nxt_trst;
                     per_q    <= per_q + PW'(1);
                     if (nxt_state == StShift && !op_q[1]) data_q <= data_q >> 1;
                  end
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= StReady;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= StReady;
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_err      = rsp_err_q;
   assign rsp_undriven = rsp_undriven_q;
   assign busy         = busy_q;
   assign jtag_TCK     = tck_q;
   assign jtag_TMS     = tms_q;
   assign jtag_TDI     = tdi_q;
   assign jtag_TRSTn   = trst_q;

endmodule
